// File: rtl/fifo_flops.sv
// Single-clock show-ahead FIFO built from a flip-flop register array.
// Dout always presents the oldest stored word; full/pndng decode directly from count.
module fifo_flops #(
  parameter int depth = 16,
  parameter int bits  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] Din,
  input  logic            push,
  input  logic            pop,
  output logic [bits-1:0] Dout,
  output logic            full,
  output logic            pndng
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);

  logic [bits-1:0] storage [depth];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            push_ok;
  logic            pop_ok;

  // Explicit compare so depths that are not a power of two wrap correctly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(depth - 1)) return '0;
    else                     return p + 1'b1;
  endfunction

  assign full    = (count == CW'(depth));
  assign pndng   = (count != '0);
  assign Dout    = storage[rd_ptr];
  assign pop_ok  = pop & pndng;
  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < depth; i++) storage[i] <= '0;
    end else begin
      if (push_ok) begin
        storage[wr_ptr] <= Din;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_flops.sv
// Directed self-checking bench for fifo_flops (depth=16, bits=16).
module tb_fifo_flops;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Din;
  logic        push;
  logic        pop;
  logic [15:0] Dout;
  logic        full;
  logic        pndng;

  int n_chk  = 0;
  int n_fail = 0;

  fifo_flops #(16, 16) dut (
    .clk  (clk),
    .rst  (rst),
    .Din  (Din),
    .push (push),
    .pop  (pop),
    .Dout (Dout),
    .full (full),
    .pndng(pndng)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic ps, input logic pp, input logic [15:0] d);
    push = ps;
    pop  = pp;
    Din  = d;
    step();
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_count"}, 32'(dut.count), 32'd0);
    check({tag, "_pndng"}, 32'(pndng), 32'd0);
    check({tag, "_full"},  32'(full), 32'd0);
  endtask

  initial begin
    rst  = 1'b1;
    push = 1'b0;
    pop  = 1'b0;
    Din  = '0;
    repeat (5) step();
    check_empty("reset");
    check("reset_dout", 32'(Dout), 32'd0);
    rst = 1'b0;
    step();

    // Fill on alternate cycles, then drain.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 16'(i));
      check("fill_count", 32'(dut.count), 32'(i + 1));
      check("fill_full", 32'(full), (i == 15) ? 32'd1 : 32'd0);
      cyc(1'b0, 1'b0, 16'hFFFF);
    end
    for (int i = 0; i < 16; i++) begin
      check("drain_dout", 32'(Dout), 32'(i));
      cyc(1'b0, 1'b1, 16'h0);
    end
    check_empty("drain");

    // Overflow: pushes beyond 16 are dropped.
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 16'(i));
    check("ovf_count", 32'(dut.count), 32'd16);
    check("ovf_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("ovf_dout", 32'(Dout), 32'(i));
      cyc(1'b0, 1'b1, 16'h0);
    end
    check_empty("ovf_end");

    // Underflow: pops on empty are ignored.
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 16'h0);
    check_empty("unf");
    cyc(1'b1, 1'b0, 16'h00AA);
    check("unf_dout", 32'(Dout), 32'h00AA);
    cyc(1'b0, 1'b1, 16'h0);
    check_empty("unf_end");

    // Push+pop on empty: only the push lands.
    cyc(1'b1, 1'b1, 16'd5);
    check("sim1_count", 32'(dut.count), 32'd1);
    check("sim1_dout", 32'(Dout), 32'd5);
    cyc(1'b0, 1'b1, 16'h0);

    // Push+pop mid-occupancy.
    for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 16'(i));
    check("sim2_dout0", 32'(Dout), 32'd1);
    cyc(1'b1, 1'b1, 16'd4);
    check("sim2_count", 32'(dut.count), 32'd3);
    for (int i = 2; i <= 4; i++) begin
      check("sim2_dout", 32'(Dout), 32'(i));
      cyc(1'b0, 1'b1, 16'h0);
    end
    check_empty("sim2_end");

    // Push+pop when full: new word goes into the freed slot, emerges last.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 16'(16'h100 + i));
    cyc(1'b1, 1'b1, 16'hBEEF);
    check("sim3_count", 32'(dut.count), 32'd16);
    check("sim3_full", 32'(full), 32'd1);
    for (int i = 1; i < 16; i++) begin
      check("sim3_dout", 32'(Dout), 32'(16'h100 + i));
      cyc(1'b0, 1'b1, 16'h0);
    end
    check("sim3_last", 32'(Dout), 32'hBEEF);
    cyc(1'b0, 1'b1, 16'h0);
    check_empty("sim3_end");

    // Interleaved push/pop drives the pointers around several wraps.
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, 1'b0, 16'(k * 3 + 7));
      check("il_count1", 32'(dut.count), 32'd1);
      check("il_dout", 32'(Dout), 32'(k * 3 + 7));
      cyc(1'b0, 1'b1, 16'h0);
      check("il_count0", 32'(dut.count), 32'd0);
    end

    // Asynchronous reset between edges with 7 words stored.
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 16'(16'h50 + i));
    check("mid_count", 32'(dut.count), 32'd7);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_empty("mid_rst");
    check("mid_rst_dout", 32'(Dout), 32'd0);
    #2 rst = 1'b0;
    step();
    cyc(1'b1, 1'b0, 16'h0033);
    check("post_count", 32'(dut.count), 32'd1);
    check("post_dout", 32'(Dout), 32'h0033);
    cyc(1'b0, 1'b1, 16'h0);
    check_empty("post_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
